// File: rtl/baud_tick_sched.sv
// Shared baud divider: oversample, bit-centre and bit-end enables.
// Divisor is reloaded via valid/ready and re-phased by RX start-bit sync.
module baud_tick_sched #(
    parameter int CLK_FREQ = 48_000_000,
    parameter int DEF_DIV  = 26,
    parameter int DIV_W    = 16,
    parameter int OVS      = 16
) (
    input  logic             clkIN,
    input  logic             nResetIN,
    input  logic             enIN,
    input  logic             rxSyncIN,
    input  logic [DIV_W-1:0] cfgDivIN,
    input  logic             cfgValidIN,
    output logic             cfgReadyOUT,
    output logic             ovsTickOUT,
    output logic             midTickOUT,
    output logic             bitTickOUT,
    output logic [DIV_W-1:0] divOUT
);

    localparam int SUB_W = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    if (OVS < 4 || (OVS % 2) != 0 || CLK_FREQ < DEF_DIV * OVS) begin : gBadCfg
        $error("baud_tick_sched: unsupported parameter set");
    end

    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pendDiv;
    logic [SUB_W-1:0] sub;
    logic             ovsTick;
    logic             midTick;
    logic             bitTick;
    logic             cfgReady;

    logic [DIV_W-1:0] cfgClamp;
    logic [DIV_W-1:0] nextDiv;
    logic             xfer;
    logic             isPend;
    logic             atZero;
    logic             lastSub;
    logic             boundary;

    always_comb begin
        cfgClamp = (cfgDivIN < DIV_W'(2)) ? DIV_W'(2) : cfgDivIN;
        xfer     = cfgValidIN & cfgReady;
        isPend   = (state == S_PEND);
        atZero   = (cnt == '0);
        lastSub  = (sub == SUB_W'(OVS - 1));
        boundary = atZero & lastSub;
        // Divisor to use whenever the bit phase restarts.
        nextDiv  = isPend ? pendDiv : div;
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state    <= S_IDLE;
            div      <= DIV_W'(DEF_DIV);
            cnt      <= DIV_W'(DEF_DIV - 1);
            pendDiv  <= DIV_W'(DEF_DIV);
            sub      <= '0;
            ovsTick  <= 1'b0;
            midTick  <= 1'b0;
            bitTick  <= 1'b0;
            cfgReady <= 1'b1;
        end else begin
            ovsTick <= 1'b0;
            midTick <= 1'b0;
            bitTick <= 1'b0;
            if (state == S_IDLE) begin
                cfgReady <= 1'b1;
                if (xfer) begin
                    div <= cfgClamp;
                    cnt <= cfgClamp - 1'b1;
                end
                if (enIN) begin
                    state <= S_RUN;
                end
            end else if (!enIN) begin
                state    <= S_IDLE;
                sub      <= '0;
                cfgReady <= 1'b1;
                if (isPend) begin
                    div <= pendDiv;
                    cnt <= pendDiv - 1'b1;
                end else if (xfer) begin
                    div <= cfgClamp;
                    cnt <= cfgClamp - 1'b1;
                end else begin
                    cnt <= div - 1'b1;
                end
            end else begin
                if (rxSyncIN) begin
                    cnt <= nextDiv - 1'b1;
                    sub <= '0;
                end else if (atZero) begin
                    cnt     <= (boundary ? nextDiv : div) - 1'b1;
                    sub     <= lastSub ? '0 : sub + 1'b1;
                    ovsTick <= 1'b1;
                    midTick <= (sub == SUB_W'(OVS / 2 - 1));
                    bitTick <= boundary;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                // Ready stays low for one cycle after a pending divisor lands.
                if (isPend) begin
                    if (rxSyncIN || boundary) begin
                        div   <= pendDiv;
                        state <= S_RUN;
                    end
                end else if (xfer) begin
                    pendDiv  <= cfgClamp;
                    state    <= S_PEND;
                    cfgReady <= 1'b0;
                end else begin
                    cfgReady <= 1'b1;
                end
            end
        end
    end

    assign cfgReadyOUT = cfgReady;
    assign ovsTickOUT  = ovsTick;
    assign midTickOUT  = midTick;
    assign bitTickOUT  = bitTick;
    assign divOUT      = div;

endmodule

// File: tb/tb_baud_tick_sched.sv
// Bench for baud_tick_sched: time-based tick model plus directed scenarios.
// Model derives tick slots from phase origin and divisor, not from counters.
module tb_baud_tick_sched;

    localparam int DEF = 4;
    localparam int OVS = 16;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         en = 1'b0;
    logic         sync = 1'b0;
    logic         cfgV = 1'b0;
    logic [W-1:0] cfgD = '0;
    logic         cfgReady;
    logic         ovs;
    logic         mid;
    logic         bitT;
    logic [W-1:0] divO;

    baud_tick_sched #(
        .CLK_FREQ(48_000_000),
        .DEF_DIV (DEF),
        .DIV_W   (W),
        .OVS     (OVS)
    ) dut (
        .clkIN      (clk),
        .nResetIN   (rstN),
        .enIN       (en),
        .rxSyncIN   (sync),
        .cfgDivIN   (cfgD),
        .cfgValidIN (cfgV),
        .cfgReadyOUT(cfgReady),
        .ovsTickOUT (ovs),
        .midTickOUT (mid),
        .bitTickOUT (bitT),
        .divOUT     (divO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int t = 0;
    bit mRun = 0;
    bit mPend = 0;
    bit mReady = 1;
    int mDiv = DEF;
    int mPdiv = DEF;
    int mOrg = 0;
    bit eOvs = 0;
    bit eMid = 0;
    bit eBit = 0;
    int tEn = 0;
    int tReadyRise = -1;
    int ovsQ[$];
    int midQ[$];
    int bitQ[$];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int firstAfter(input int q[$], input int x);
        foreach (q[i]) if (q[i] > x) return q[i];
        return -1;
    endfunction

    task automatic clearQ();
        ovsQ.delete();
        midQ.delete();
        bitQ.delete();
    endtask

    // Expected outputs after this edge, from the divisor and phase origin.
    task automatic modelStep();
        bit xf;
        bit wasPend;
        int cl;
        int d;
        int n;
        int s;
        cl = (cfgD < 2) ? 2 : int'(cfgD);
        xf = cfgV && mReady;
        eOvs = 0;
        eMid = 0;
        eBit = 0;
        if (!rstN) begin
            mRun = 0;
            mPend = 0;
            mDiv = DEF;
            mReady = 1;
        end else if (!mRun) begin
            if (xf) mDiv = cl;
            mReady = 1;
            if (en) begin
                mRun = 1;
                mOrg = t;
                tEn = t;
            end
        end else if (!en) begin
            mRun = 0;
            if (mPend) mDiv = mPdiv;
            else if (xf) mDiv = cl;
            mPend = 0;
            mReady = 1;
        end else begin
            wasPend = mPend;
            if (sync) begin
                mOrg = t;
                if (mPend) begin
                    mDiv = mPdiv;
                    mPend = 0;
                end
            end else begin
                d = t - mOrg;
                if (d % mDiv == 0) begin
                    n = d / mDiv;
                    s = (n - 1) % OVS;
                    eOvs = 1;
                    eMid = (s == OVS / 2 - 1);
                    eBit = (s == OVS - 1);
                    if (eBit) begin
                        mOrg = t;
                        if (mPend) begin
                            mDiv = mPdiv;
                            mPend = 0;
                        end
                    end
                end
            end
            if (wasPend) begin
                mReady = 0;
            end else if (xf) begin
                mPend = 1;
                mPdiv = cl;
                mReady = 0;
            end else begin
                if (!mReady) tReadyRise = t;
                mReady = 1;
            end
        end
        if (eOvs) ovsQ.push_back(t);
        if (eMid) midQ.push_back(t);
        if (eBit) bitQ.push_back(t);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            chk("ovsTick", ovs, eOvs);
            chk("midTick", mid, eMid);
            chk("bitTick", bitT, eBit);
            chk("cfgReady", cfgReady, mReady);
            chk("divOUT", divO, mDiv);
            t++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int v);
        cfgD = W'(v);
        cfgV = 1'b1;
        cyc(1);
        cfgV = 1'b0;
    endtask

    int k;
    int tS;

    initial begin
        cyc(3);
        chk("rst_div", divO, DEF);
        chk("rst_ready", cfgReady, 1);
        chk("rst_ovs", ovs, 0);
        rstN = 1'b1;
        cyc(1);

        // default divisor, first ticks and bit period
        clearQ();
        en = 1'b1;
        cyc(140);
        chk("t1_first_ovs", qAt(ovsQ, 0) - tEn, 4);
        chk("t1_first_mid", qAt(midQ, 0) - tEn, 32);
        chk("t1_first_bit", qAt(bitQ, 0) - tEn, 64);
        chk("t1_bit_period", qAt(bitQ, 1) - qAt(bitQ, 0), 64);

        // idle reconfiguration
        en = 1'b0;
        cyc(1);
        wr(10);
        chk("t2_div", divO, 10);
        clearQ();
        en = 1'b1;
        cyc(40);
        chk("t2_first_ovs", qAt(ovsQ, 0) - tEn, 10);
        chk("t2_ovs_period", qAt(ovsQ, 1) - qAt(ovsQ, 0), 10);

        // running reconfiguration lands on the bit boundary
        en = 1'b0;
        cyc(1);
        wr(4);
        clearQ();
        en = 1'b1;
        cyc(20);
        wr(8);
        chk("t3_ready_low", cfgReady, 0);
        chk("t3_div_hold", divO, 4);
        cyc(220);
        chk("t3_bit0", qAt(bitQ, 0) - tEn, 64);
        chk("t3_ready_back", tReadyRise - tEn, 65);
        chk("t3_next_ovs", firstAfter(ovsQ, qAt(bitQ, 0)) - qAt(bitQ, 0), 8);
        chk("t3_bit_period", qAt(bitQ, 1) - qAt(bitQ, 0), 128);
        chk("t3_div", divO, 8);

        // clamp
        en = 1'b0;
        cyc(1);
        wr(0);
        chk("t4_clamp0", divO, 2);
        wr(7);
        chk("t4_div7", divO, 7);
        wr(1);
        chk("t4_clamp1", divO, 2);
        clearQ();
        en = 1'b1;
        cyc(20);
        chk("t4_ovs_period", qAt(ovsQ, 1) - qAt(ovsQ, 0), 2);

        // rxSync re-phase, then sync while a divisor is pending
        en = 1'b0;
        cyc(1);
        wr(4);
        clearQ();
        en = 1'b1;
        cyc(37);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        cyc(40);
        chk("t5_ovs_after_sync", firstAfter(ovsQ, tEn + 37) - tEn, 41);
        chk("t5_mid_after_sync", firstAfter(midQ, tEn + 37) - tEn, 69);
        wr(8);
        cyc(5);
        chk("t5_pend_hold", divO, 4);
        tS = t;
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        chk("t5_pend_applied", divO, 8);
        cyc(20);
        chk("t5_ovs_new_div", firstAfter(ovsQ, tS) - tS, 8);

        // abort: disable applies pending divisor, reset discards it
        wr(10);
        cyc(10);
        chk("t6_pend_hold", divO, 8);
        en = 1'b0;
        cyc(1);
        chk("t6_disable_div", divO, 10);
        chk("t6_disable_ready", cfgReady, 1);
        k = ovsQ.size();
        cyc(10);
        chk("t6_no_ticks", ovsQ.size(), k);
        en = 1'b1;
        cyc(50);
        wr(6);
        cyc(7);
        rstN = 1'b0;
        en = 1'b0;
        #1;
        chk("t6_rst_div", divO, DEF);
        chk("t6_rst_ready", cfgReady, 1);
        chk("t6_rst_ovs", ovs, 0);
        cyc(3);
        rstN = 1'b1;
        cyc(1);
        clearQ();
        en = 1'b1;
        cyc(70);
        chk("t6_after_rst_bit", qAt(bitQ, 0) - tEn, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
